// File: rtl/stone_hook_detector_if.sv
// Bus between the rope controller / shared stone RAM and the hook detector.
// The master side issues requests and returns RAM read data. The slave side is the detector.
interface stone_hook_detector_if #(
  parameter int ADDR_W = 4
);
  logic              check_req;
  logic              move_req;
  logic              clear_req;
  logic [9:0]        end_x;
  logic [9:0]        end_y;
  logic [ADDR_W-1:0] sel_index;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_q;
  logic              mem_wren;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              hit;
  logic [ADDR_W-1:0] hit_index;
  logic [1:0]        hit_kind;
  logic [4:0]        score_add;

  modport master (
    output check_req, move_req, clear_req, end_x, end_y, sel_index, mem_q,
    input  mem_addr, mem_wren, mem_wdata, busy, done, hit, hit_index, hit_kind, score_add
  );

  modport slave (
    input  check_req, move_req, clear_req, end_x, end_y, sel_index, mem_q,
    output mem_addr, mem_wren, mem_wdata, busy, done, hit, hit_index, hit_kind, score_add
  );
endinterface

// File: rtl/stone_hook_detector.sv
// Hook/stone hit detection, stone move and stone clear over a shared 16 x 32 stone RAM.
// Stone word: [31] alive, [30:29] kind, [28:19] x, [18:9] y, [8:5] radius, [4:0] value.
//
// state   | meaning
// IDLE    | waiting for a request (clear > move > check)
// RD_ADDR | check: mem_addr = idx, RAM read in flight
// COMPARE | check: evaluate mem_q for stone idx
// M_RD    | move: mem_addr = sel_index
// M_WAIT  | move: mem_q valid, build the rewritten word
// M_WR    | move: write the word back
// C_RD    | clear: mem_addr = sel_index
// C_WAIT  | clear: mem_q valid, build the killed word and score
// C_WR    | clear: write the word back
// DONE    | done pulse, busy released afterwards
module stone_hook_detector #(
  parameter int NUM_STONES = 16,
  parameter int ADDR_W     = 4
) (
  input logic                  clock,
  input logic                  reset,
  stone_hook_detector_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, RD_ADDR, COMPARE, M_RD, M_WAIT, M_WR, C_RD, C_WAIT, C_WR, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_STONES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [9:0]        ex_q, ex_d;
  logic [9:0]        ey_q, ey_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hit_q, hit_d;
  logic [ADDR_W-1:0] hidx_q, hidx_d;
  logic [1:0]        hkind_q, hkind_d;
  logic [4:0]        score_q, score_d;
  logic              clr_q, clr_d;

  logic signed [10:0] dx, dy;
  logic [10:0]        adx, ady;
  logic               stone_hit;

  // Hook coordinates are unsigned 10-bit, so an 11-bit signed difference never overflows.
  always_comb begin
    dx        = $signed({1'b0, ex_q}) - $signed({1'b0, bus.mem_q[28:19]});
    dy        = $signed({1'b0, ey_q}) - $signed({1'b0, bus.mem_q[18:9]});
    adx       = dx[10] ? $unsigned(-dx) : $unsigned(dx);
    ady       = dy[10] ? $unsigned(-dy) : $unsigned(dy);
    stone_hit = bus.mem_q[31] &&
                (adx <= {7'd0, bus.mem_q[8:5]}) &&
                (ady <= {7'd0, bus.mem_q[8:5]});
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      ex_q    <= '0;
      ey_q    <= '0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
      hidx_q  <= '0;
      hkind_q <= '0;
      score_q <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      wdata_q <= wdata_d;
      hit_q   <= hit_d;
      hidx_q  <= hidx_d;
      hkind_q <= hkind_d;
      score_q <= score_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    wdata_d = wdata_q;
    hit_d   = hit_q;
    hidx_d  = hidx_q;
    hkind_d = hkind_q;
    score_d = score_q;
    clr_d   = clr_q;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          clr_d   = 1'b1;
          addr_d  = bus.sel_index;
          state_d = C_RD;
        end else if (bus.move_req) begin
          clr_d   = 1'b0;
          addr_d  = bus.sel_index;
          ex_d    = bus.end_x;
          ey_d    = bus.end_y;
          state_d = M_RD;
        end else if (bus.check_req) begin
          clr_d   = 1'b0;
          ex_d    = bus.end_x;
          ey_d    = bus.end_y;
          idx_d   = '0;
          addr_d  = '0;
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: state_d = COMPARE;
      COMPARE: begin
        if (stone_hit) begin
          hit_d   = 1'b1;
          hidx_d  = idx_q;
          hkind_d = bus.mem_q[30:29];
          state_d = DONE;
        end else if (idx_q == LAST_IDX) begin
          hit_d   = 1'b0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          addr_d  = idx_q + ADDR_W'(1);
          state_d = RD_ADDR;
        end
      end
      M_RD: state_d = M_WAIT;
      M_WAIT: begin
        wdata_d = {bus.mem_q[31:29], ex_q, ey_q, bus.mem_q[8:0]};
        state_d = M_WR;
      end
      M_WR: state_d = DONE;
      C_RD: state_d = C_WAIT;
      C_WAIT: begin
        wdata_d = {1'b0, bus.mem_q[30:0]};
        score_d = bus.mem_q[31] ? bus.mem_q[4:0] : 5'd0;
        state_d = C_WR;
      end
      C_WR: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wren  = (state_q == M_WR) || (state_q == C_WR);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.hit       = hit_q;
  assign bus.hit_index = hidx_q;
  assign bus.hit_kind  = hkind_q;
  assign bus.score_add = ((state_q == DONE) && clr_q) ? score_q : 5'd0;

endmodule

// File: tb/tb_stone_hook_detector.sv
// Bench for stone_hook_detector: behavioural stone RAM, a vector table of operations
// with hand-computed results, and directed sequences for busy-drop and mid-op reset.
module tb_stone_hook_detector;

  typedef struct {
    logic [2:0] op;      // {clear, move, check}
    logic [9:0] ex;
    logic [9:0] ey;
    logic [3:0] sel;
    int         cyc;
    logic       hit;
    logic [3:0] idx;
    logic [1:0] kind;
    logic [4:0] score;
    int         wr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   wr_cnt = 0;

  logic [31:0] ram [16];
  logic [31:0] img [16];
  logic        ld = 1'b0;

  stone_hook_detector_if bus ();

  stone_hook_detector #(.NUM_STONES(16), .ADDR_W(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data for the address seen at an edge appears after that edge.
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 16; i++) ram[i] <= img[i];
    end else if (bus.mem_wren) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_q <= ram[bus.mem_addr];
    if (bus.mem_wren) wr_cnt <= wr_cnt + 1;
  end

  function automatic logic [31:0] mk(input logic a, input logic [1:0] k, input logic [9:0] x,
                                     input logic [9:0] y, input logic [3:0] r, input logic [4:0] v);
    return {a, k, x, y, r, v};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic load_ram();
    @(negedge clk);
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [9:0] ex, input logic [9:0] ey,
                        input logic [3:0] sel, output int cyc, output logic [4:0] sc,
                        output int wr, output logic b1, output logic leak);
    int w0;
    @(negedge clk);
    bus.clear_req = op[2];
    bus.move_req  = op[1];
    bus.check_req = op[0];
    bus.end_x     = ex;
    bus.end_y     = ey;
    bus.sel_index = sel;
    w0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.clear_req = 1'b0;
    bus.move_req  = 1'b0;
    bus.check_req = 1'b0;
    bus.end_x     = ~ex;
    bus.end_y     = ~ey;
    bus.sel_index = ~sel;
    cyc  = 0;
    sc   = '0;
    leak = 1'b0;
    b1   = bus.busy;
    for (int n = 1; n <= 100; n++) begin
      if (n > 1) @(negedge clk);
      if (bus.done) begin
        cyc = n;
        sc  = bus.score_add;
        break;
      end
      if (bus.score_add != 5'd0) leak = 1'b1;
    end
    wr = wr_cnt - w0;
  endtask

  vec_t       tv [17];
  int         cyc, wr, w0;
  logic [4:0] sc;
  logic       b1, leak, seen_done, seen_wren;

  initial begin
    bus.check_req = 1'b0;
    bus.move_req  = 1'b0;
    bus.clear_req = 1'b0;
    bus.end_x     = '0;
    bus.end_y     = '0;
    bus.sel_index = '0;
    for (int i = 0; i < 16; i++) img[i] = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_addr",  int'(bus.mem_addr),  0);
    chk("rst_wren",  int'(bus.mem_wren),  0);
    chk("rst_wdata", int'(bus.mem_wdata), 0);
    chk("rst_busy",  int'(bus.busy),      0);
    chk("rst_done",  int'(bus.done),      0);
    chk("rst_hit",   int'(bus.hit),       0);
    chk("rst_hidx",  int'(bus.hit_index), 0);
    chk("rst_kind",  int'(bus.hit_kind),  0);
    chk("rst_score", int'(bus.score_add), 0);

    // All stones dead: full scan, no hit, no writes.
    load_ram();
    run_op(3'b001, 10'd0, 10'd0, 4'd0, cyc, sc, wr, b1, leak);
    chk("dead_cyc",  cyc, 33);
    chk("dead_hit",  int'(bus.hit), 0);
    chk("dead_wr",   wr, 0);
    chk("dead_busy", int'(b1), 1);

    img[2]  = mk(1'b1, 2'd1, 10'd50,  10'd50,   4'd3,  5'd4);
    img[3]  = mk(1'b1, 2'd2, 10'd100, 10'd80,   4'd5,  5'd9);
    img[5]  = mk(1'b1, 2'd3, 10'd52,  10'd51,   4'd4,  5'd6);
    img[7]  = mk(1'b1, 2'd0, 10'd900, 10'd900,  4'd1,  5'd20);
    img[9]  = mk(1'b0, 2'd1, 10'd300, 10'd300,  4'd7,  5'd11);
    img[12] = mk(1'b1, 2'd0, 10'd0,   10'd1023, 4'd15, 5'd31);
    load_ram();

    tv[0]  = '{3'b001, 10'd104, 10'd76,   4'd0, 9,  1'b1, 4'd3,  2'd2, 5'd0,  0};
    tv[1]  = '{3'b001, 10'd105, 10'd80,   4'd0, 9,  1'b1, 4'd3,  2'd2, 5'd0,  0};
    tv[2]  = '{3'b001, 10'd106, 10'd80,   4'd0, 33, 1'b0, 4'd3,  2'd2, 5'd0,  0};
    tv[3]  = '{3'b001, 10'd100, 10'd75,   4'd0, 9,  1'b1, 4'd3,  2'd2, 5'd0,  0};
    tv[4]  = '{3'b001, 10'd50,  10'd50,   4'd0, 7,  1'b1, 4'd2,  2'd1, 5'd0,  0};
    tv[5]  = '{3'b001, 10'd56,  10'd51,   4'd0, 13, 1'b1, 4'd5,  2'd3, 5'd0,  0};
    tv[6]  = '{3'b001, 10'd300, 10'd300,  4'd0, 33, 1'b0, 4'd5,  2'd3, 5'd0,  0};
    tv[7]  = '{3'b001, 10'd10,  10'd1010, 4'd0, 27, 1'b1, 4'd12, 2'd0, 5'd0,  0};
    tv[8]  = '{3'b001, 10'd0,   10'd0,    4'd0, 33, 1'b0, 4'd12, 2'd0, 5'd0,  0};
    tv[9]  = '{3'b010, 10'd60,  10'd60,   4'd9, 4,  1'b0, 4'd12, 2'd0, 5'd0,  1};
    tv[10] = '{3'b101, 10'd900, 10'd900,  4'd7, 4,  1'b0, 4'd12, 2'd0, 5'd20, 1};
    tv[11] = '{3'b100, 10'd0,   10'd0,    4'd7, 4,  1'b0, 4'd12, 2'd0, 5'd0,  1};
    tv[12] = '{3'b100, 10'd0,   10'd0,    4'd9, 4,  1'b0, 4'd12, 2'd0, 5'd0,  1};
    tv[13] = '{3'b001, 10'd900, 10'd900,  4'd0, 33, 1'b0, 4'd12, 2'd0, 5'd0,  0};
    tv[14] = '{3'b001, 10'd61,  10'd59,   4'd0, 33, 1'b0, 4'd12, 2'd0, 5'd0,  0};
    tv[15] = '{3'b010, 10'd200, 10'd150,  4'd3, 4,  1'b0, 4'd12, 2'd0, 5'd0,  1};
    tv[16] = '{3'b001, 10'd203, 10'd147,  4'd0, 9,  1'b1, 4'd3,  2'd2, 5'd0,  0};

    for (int i = 0; i < 17; i++) begin
      run_op(tv[i].op, tv[i].ex, tv[i].ey, tv[i].sel, cyc, sc, wr, b1, leak);
      chk($sformatf("v%0d_cyc", i),   cyc, tv[i].cyc);
      chk($sformatf("v%0d_hit", i),   int'(bus.hit), int'(tv[i].hit));
      chk($sformatf("v%0d_hidx", i),  int'(bus.hit_index), int'(tv[i].idx));
      chk($sformatf("v%0d_kind", i),  int'(bus.hit_kind), int'(tv[i].kind));
      chk($sformatf("v%0d_score", i), int'(sc), int'(tv[i].score));
      chk($sformatf("v%0d_wr", i),    wr, tv[i].wr);
      chk($sformatf("v%0d_busy", i),  int'(b1), 1);
      chk($sformatf("v%0d_leak", i),  int'(leak), 0);
      @(negedge clk);
      chk($sformatf("v%0d_idle", i),  int'(bus.busy), 0);
      chk($sformatf("v%0d_sc0", i),   int'(bus.score_add), 0);
    end
    chk("ram9_moved",  int'(ram[9]), int'(mk(1'b0, 2'd1, 10'd60,  10'd60,  4'd7, 5'd11)));
    chk("ram7_killed", int'(ram[7]), int'(mk(1'b0, 2'd0, 10'd900, 10'd900, 4'd1, 5'd20)));
    chk("ram3_moved",  int'(ram[3]), int'(mk(1'b1, 2'd2, 10'd200, 10'd150, 4'd5, 5'd9)));

    // Requests while busy are dropped.
    @(negedge clk);
    bus.check_req = 1'b1;
    bus.end_x = 10'd1000;
    bus.end_y = 10'd5;
    w0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.check_req = 1'b0;
    cyc = 0;
    for (int n = 1; n <= 100; n++) begin
      if (n > 1) @(negedge clk);
      bus.move_req  = (n == 4);
      bus.clear_req = (n == 6);
      bus.sel_index = 4'd2;
      if (bus.done) begin
        cyc = n;
        break;
      end
    end
    bus.move_req  = 1'b0;
    bus.clear_req = 1'b0;
    chk("drop_cyc",  cyc, 33);
    chk("drop_hit",  int'(bus.hit), 0);
    chk("drop_hidx", int'(bus.hit_index), 3);
    repeat (3) @(negedge clk);
    chk("drop_busy", int'(bus.busy), 0);
    chk("drop_wr",   wr_cnt - w0, 0);
    chk("drop_ram2", int'(ram[2]), int'(mk(1'b1, 2'd1, 10'd50, 10'd50, 4'd3, 5'd4)));

    // Move stone 4, then reset during a second move's M_WAIT.
    run_op(3'b010, 10'd200, 10'd150, 4'd4, cyc, sc, wr, b1, leak);
    chk("mv4_cyc", cyc, 4);
    chk("mv4_wr",  wr, 1);
    @(negedge clk);
    chk("mv4_ram", int'(ram[4]), int'(mk(1'b0, 2'd0, 10'd200, 10'd150, 4'd0, 5'd0)));
    bus.move_req  = 1'b1;
    bus.sel_index = 4'd4;
    bus.end_x     = 10'd1;
    bus.end_y     = 10'd2;
    w0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.move_req = 1'b0;
    chk("mv2_busy", int'(bus.busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ar_addr",  int'(bus.mem_addr),  0);
    chk("ar_wren",  int'(bus.mem_wren),  0);
    chk("ar_wdata", int'(bus.mem_wdata), 0);
    chk("ar_busy",  int'(bus.busy),      0);
    chk("ar_done",  int'(bus.done),      0);
    chk("ar_hit",   int'(bus.hit),       0);
    chk("ar_hidx",  int'(bus.hit_index), 0);
    chk("ar_kind",  int'(bus.hit_kind),  0);
    chk("ar_score", int'(bus.score_add), 0);
    rst = 1'b0;
    seen_done = 1'b0;
    seen_wren = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
      if (bus.mem_wren) seen_wren = 1'b1;
    end
    chk("ar_nodone", int'(seen_done), 0);
    chk("ar_nowren", int'(seen_wren), 0);
    chk("ar_wr",     wr_cnt - w0, 0);
    chk("ar_ram4",   int'(ram[4]), int'(mk(1'b0, 2'd0, 10'd200, 10'd150, 4'd0, 5'd0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
